// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller.
// Segment bit order is {a,b,c,d,e,f,g} with a as bit 6.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] SEG_HEX_0 = 7'b1111110;
  localparam logic [6:0] SEG_HEX_1 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_2 = 7'b1101101;
  localparam logic [6:0] SEG_HEX_3 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_4 = 7'b0110011;
  localparam logic [6:0] SEG_HEX_5 = 7'b1011011;
  localparam logic [6:0] SEG_HEX_6 = 7'b1011111;
  localparam logic [6:0] SEG_HEX_7 = 7'b1110000;
  localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
  localparam logic [6:0] SEG_HEX_9 = 7'b1111011;
  localparam logic [6:0] SEG_HEX_A = 7'b1110111;
  localparam logic [6:0] SEG_HEX_B = 7'b0011111;
  localparam logic [6:0] SEG_HEX_C = 7'b1001110;
  localparam logic [6:0] SEG_HEX_D = 7'b0111101;
  localparam logic [6:0] SEG_HEX_E = 7'b1001111;
  localparam logic [6:0] SEG_HEX_F = 7'b1000111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display data/pin bundle between the datapath side
// and the scan controller.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] din;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    lz_en;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output din, dp_in, load, lz_en,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  din, dp_in, load, lz_en,
    output seg, dp, an, frame_done
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to segment pattern lookup.
// Active-high segments, {a..g}.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nib)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner, MSB digit first,
// with per-slot blanking and frame-aligned display updates.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = ($clog2(NUM_DIGITS) < 1) ? 1
                    : $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_TOP    = IW'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  scan_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  digits_t               pend_q, pend_d;
  digits_t               shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q, fd_d;

  logic                  slot_end;
  logic                  frame_end;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] supp;
  logic [6:0]            hex_seg;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == '0);

  always_comb begin : scan_next
    cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    state_d = state_q;
    if (slot_end) begin
      idx_d = (idx_q == '0) ? IDX_TOP : idx_q - 1'b1;
    end
    unique case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
      ST_SHOW:  if (slot_end) state_d = ST_BLANK;
    endcase
  end

  // pend_d already folds in a same-cycle load, so a load on the
  // frame boundary goes straight to the display.
  always_comb begin : data_next
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    if (bus.load) begin
      pend_d    = bus.din;
      pend_dp_d = bus.dp_in;
    end
    if (frame_end) begin
      shadow_d    = pend_d;
      shadow_dp_d = pend_dp_d;
    end
  end

  always_comb begin : lz_mask
    zero_run = 1'b1;
    supp     = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (shadow_q[k] == 4'h0);
      supp[k]  = zero_run && !shadow_dp_q[k];
    end
  end

  seg7_hex_decode u_dec (
    .nib (shadow_q[idx_q]),
    .seg (hex_seg)
  );

  // Suppressed digits still pull their anode low to keep duty uniform.
  always_comb begin : out_next
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    an_d  = '1;
    fd_d  = frame_end;
    if (state_q == ST_SHOW) begin
      an_d[idx_q] = 1'b0;
      if (!(bus.lz_en && supp[idx_q])) begin
        seg_d = hex_seg;
        dp_d  = shadow_dp_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BLANK;
      cnt_q       <= '0;
      idx_q       <= IDX_TOP;
      pend_q      <= '0;
      pend_dp_q   <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b0;
      an_q        <= '1;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_dp_q   <= pend_dp_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      fd_q        <= fd_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: per-cycle expected pin
// values are queued when data is loaded and checked at negedge.
module tb_seg7_scan_ctrl;

  localparam int ND  = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int FR  = ND * DIV;
  localparam int NV  = 10;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SA = 7'b1110111;
  localparam logic [6:0] SB = 7'b0011111;
  localparam logic [6:0] SC = 7'b1001110;
  localparam logic [6:0] SD = 7'b0111101;
  localparam logic [6:0] SE = 7'b1001111;
  localparam logic [6:0] SF = 7'b1000111;
  localparam logic [6:0] SZ = 7'b0000000;

  typedef struct {
    logic [15:0]     din;
    logic [3:0]      dpi;
    logic            lz;
    logic [3:0][6:0] seg;
    logic [3:0]      xdp;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q[$];
  vec_t tbl[NV];

  seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (DIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [31:0] pk(logic [3:0] an, logic [6:0] s,
                                     logic d, logic fd);
    return {19'b0, an, s, d, fd};
  endfunction

  function automatic logic [31:0] obs();
    return pk(bus.an, bus.seg, bus.dp, bus.frame_done);
  endfunction

  task automatic check(string nm, int at, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b (an,seg,dp,fd)",
               nm, at, act[12:0], exp[12:0]);
    end
  endtask

  // Queue the 32 observations of frame f (states f*FR..f*FR+FR-1).
  task automatic push_frame(int f, logic [3:0][6:0] s, logic [3:0] d);
    for (int p = 0; p < FR; p++) begin
      exp_t       e;
      int         pos;
      int         dig;
      logic [3:0] anx;
      pos   = p % DIV;
      dig   = ND - 1 - p / DIV;
      e.cyc = f * FR + p + 1;
      anx   = 4'b1111;
      if (pos < BLK) begin
        e.v = pk(anx, SZ, 1'b0, p == FR - 1);
      end else begin
        anx[dig] = 1'b0;
        e.v = pk(anx, s[dig], d[dig], p == FR - 1);
      end
      q.push_back(e);
    end
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_load(logic [15:0] v, logic [3:0] d);
    bus.din   = v;
    bus.dp_in = d;
    bus.load  = 1'b1;
    @(posedge clk);
    #1;
    bus.load  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && q.size() > 0 && q[0].cyc == cyc) begin
      check("scan", cyc, obs(), q[0].v);
      void'(q.pop_front());
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    tbl[0] = '{16'h5A0F, 4'b0000, 1'b0, {S5, SA, S0, SF}, 4'b0000};
    tbl[1] = '{16'h1234, 4'b0000, 1'b0, {S1, S2, S3, S4}, 4'b0000};
    tbl[2] = '{16'h0007, 4'b0000, 1'b1, {SZ, SZ, SZ, 7'b1110000},
               4'b0000};
    tbl[3] = '{16'h0000, 4'b0000, 1'b1, {SZ, SZ, SZ, S0}, 4'b0000};
    tbl[4] = '{16'h0000, 4'b0100, 1'b1, {SZ, S0, SZ, S0}, 4'b0100};
    tbl[5] = '{16'h00A0, 4'b0001, 1'b1, {SZ, SZ, SA, S0}, 4'b0001};
    tbl[6] = '{16'h5A0F, 4'b1000, 1'b0, {S5, SA, S0, SF}, 4'b1000};
    tbl[7] = '{16'hC0E0, 4'b0000, 1'b1, {SC, S0, SE, S0}, 4'b0000};
    tbl[8] = '{16'h0BD0, 4'b0000, 1'b1, {SZ, SB, SD, S0}, 4'b0000};
    tbl[9] = '{16'h0009, 4'b0000, 1'b0, {S0, S0, S0, S9}, 4'b0000};

    rst_n     = 1'b0;
    bus.din   = '0;
    bus.dp_in = '0;
    bus.load  = 1'b0;
    bus.lz_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out", cyc, obs(), pk(4'b1111, SZ, 1'b0, 1'b0));
    push_frame(0, {S0, S0, S0, S0}, 4'b0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Each vector loads mid-frame i and must appear in frame i+1.
    for (int i = 0; i < NV; i++) begin
      wait_cyc(i * FR + 10);
      push_frame(i + 1, tbl[i].seg, tbl[i].xdp);
      pulse_load(tbl[i].din, tbl[i].dpi);
      wait_cyc((i + 1) * FR);
      bus.lz_en = tbl[i].lz;
    end

    wait_cyc(NV * FR + 5);
    pulse_load(16'h1111, 4'b0000);
    wait_cyc(NV * FR + 20);
    pulse_load(16'hFFFF, 4'b0000);
    push_frame(NV + 1, {SF, SF, SF, SF}, 4'b0000);
    wait_cyc((NV + 1) * FR);
    bus.lz_en = 1'b0;

    wait_cyc((NV + 1) * FR + 10);
    pulse_load(16'h1234, 4'b0000);
    wait_cyc((NV + 1) * FR + FR - 1);
    push_frame(NV + 2, {S8, S8, S8, S8}, 4'b0000);
    push_frame(NV + 3, {S8, S8, S8, S8}, 4'b0000);
    pulse_load(16'h8888, 4'b0000);

    wait_cyc((NV + 4) * FR + 20);
    @(negedge clk);
    check("pre_reset", cyc, obs(), pk(4'b1101, S8, 1'b0, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", cyc, obs(), pk(4'b1111, SZ, 1'b0, 1'b0));
    check("drain_pre_rst", cyc, 32'(q.size()), 32'd0);
    push_frame(0, {S0, S0, S0, S0}, 4'b0000);
    push_frame(1, {S0, S0, S0, S0}, 4'b0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    wait_cyc(2 * FR + 1);
    check("drain", cyc, 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It shares one hex-to-segment decoder across `NUM_DIGITS` digits and cycles the digit enables at a fixed refresh rate. Each digit slot starts with a blanking interval so the previous digit does not ghost onto the next. It sits between the arithmetic datapaths, which supply packed hex nibbles, and the board display pins. New values load tear-free at frame boundaries.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned (2..8).
- `SCAN_DIV`, 50000: clock cycles per digit slot (≥ `BLANK_CYCLES`+2).
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all anodes off (≥1).
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `din` in 4*`NUM_DIGITS`: packed hex digits; digit *k* is `din[4k+3:4k]`; digit 0 is least significant and rightmost.
- `dp_in` in `NUM_DIGITS`: decimal-point request per digit.
- `load` in 1: capture strobe for `din`/`dp_in`.
- `lz_en` in 1: leading-zero suppression enable.
- `seg` out 7: segments {a,b,c,d,e,f,g}, with `a` as bit 6; active-high.
- `dp` out 1: decimal point, active-high.
- `an` out `NUM_DIGITS`: digit enables, active-low, at most one low at a time.
- `frame_done` out 1: one-cycle pulse at the end of each full scan.

## Operation
- Registers:
  - `pend`: data plus dp, written when `load`=1.
  - `shadow`: the displayed copy.
  - `cnt`: counts 0..`SCAN_DIV`-1.
  - `idx`: counts 0..`NUM_DIGITS`-1.
  - `state`: BLANK or SHOW.
- `cnt` increments every cycle. When it reaches `SCAN_DIV`-1 it wraps to 0 and `idx` advances.
- `idx` counts down from `NUM_DIGITS`-1 to 0, then wraps back to `NUM_DIGITS`-1. Each frame therefore scans from the most-significant digit to the least-significant digit.
- State machine:
  - BLANK → SHOW when `cnt`==`BLANK_CYCLES`-1.
  - SHOW → BLANK when `cnt`==`SCAN_DIV`-1.
  - There are no other transitions.
- Frame boundary is the cycle in which `cnt`==`SCAN_DIV`-1 and `idx`==0.
  - On this cycle `shadow` ← `pend`.
  - If `load`=1 on the same cycle, `shadow` ← `din`/`dp_in` directly, so a simultaneous load is not lost or delayed.
- A `load` asserted mid-frame only updates `pend`. The display keeps showing the old `shadow` until the next frame boundary. When several loads arrive in one frame, the last one wins.
- Decode:
  - `seg` = hex decode of `shadow` nibble[`idx`] using fixed patterns, e.g. 0→1111110, 1→0110000, 5→1011011, 8→1111111, A→1110111, F→1000111.
  - `dp` = `shadow` dp[`idx`].
- Leading-zero suppression (only when `lz_en`=1):
  - Digit *k* ≥ 1 is suppressed if its nibble and all nibbles above it are 0.
  - Digit 0 is never suppressed.
  - A suppressed digit drives `seg`=0 and `dp`=0, but `an` still goes low, so duty cycle stays uniform.
  - A digit with its dp request set is not suppressed.
- In BLANK: `an` = all ones, `seg` = 0, `dp` = 0.

## Timing
- All outputs are registered and reflect (`state`,`cnt`,`idx`,`shadow`) from the previous cycle, i.e. one cycle of latency.
- Per slot: `an` is all ones for `BLANK_CYCLES` cycles, then `an[idx]`=0 for `SCAN_DIV`-`BLANK_CYCLES` cycles.
- Frame period is `NUM_DIGITS`·`SCAN_DIV` cycles.
- `frame_done` is high for exactly 1 cycle, in the cycle after the frame boundary.
- Reset values:
  - `seg`=0, `dp`=0, `an`=all ones, `frame_done`=0.
  - `cnt`=0, `idx`=`NUM_DIGITS`-1, `state`=BLANK.
  - `pend`=0, `shadow`=0.
- Reset mid-slot: all outputs return to their reset values immediately (asynchronously). Scanning restarts with the full blank interval of the MSB digit.
- `load` has no handshake. It is sampled every cycle and is never refused.

## Structure
- Shared package `seg7_pkg` holds:
  - the 16 segment pattern constants;
  - `SEG_BLANK`=7'b0;
  - the state encoding (BLANK=0, SHOW=1).
- Sub-module `seg7_hex_decode` is a purely combinational hex→segment lookup, instantiated once and fed by the mux on `idx`.
- `cnt` width is $clog2(`SCAN_DIV`); `idx` width is $clog2(`NUM_DIGITS`), minimum 1.

## Test plan
All scenarios use `NUM_DIGITS`=4, `SCAN_DIV`=8, `BLANK_CYCLES`=2.

1. Reset, then hold → `an`=1111 and `seg`=0 for 2 cycles, then `an`=0111 for 6 cycles, then 1111, 1011, and so on. `frame_done` pulses every 32 cycles.
2. `din`=16'h5A0F loaded once → next frame shows `seg` 1011011, 1110111, 1111110, 1000111 on digits 3, 2, 1, 0.
3. Load 16'h1234 mid-frame → the current frame is unchanged. The next frame shows 1, 2, 3, 4. A second load 16'hFFFF in the same frame means only FFFF appears.
4. `lz_en`=1, `din`=16'h0007 → digits 3..1 have `seg`=0 with `an` still pulsing; digit 0 shows 1110000. Repeating with `din`=16'h0000 shows 1111110 on digit 0 only. With `dp_in`=4'b0100, digit 2 shows `seg`=1111110 and `dp`=1.
5. `load` asserted exactly on the frame-boundary cycle with 16'h8888 → the very next frame shows 8888.
6. Assert `rst_n`=0 during a SHOW slot of digit 1 → `an` goes to 1111 asynchronously. After release, the scan restarts at digit 3 with 2 blank cycles and `shadow`=0.
